// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the requester side and the transmitter side of the UART TX arbiter.
//   req       requester -> arbiter  per-requester transmit request (level)
//   req_data  requester -> arbiter  byte for requester i at [i*N +: N]
//   ack       arbiter -> requester  one-cycle pulse, byte i finished
//   err       arbiter -> requester  one-cycle pulse, transfer i timed out
//   busy      arbiter -> requester  high whenever the arbiter is not idle
//   grant_id  arbiter -> requester  current / last granted requester
//   tx_start  arbiter -> UART TX    start strobe
//   tx_din    arbiter -> UART TX    byte to send
//   tx_done   UART TX -> arbiter    completion pulse
// Modport slave is the arbiter, modport master is its environment.
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
    parameter int N    = 8,
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] req_data;
    logic [NREQ-1:0]   ack;
    logic [NREQ-1:0]   err;
    logic              busy;
    logic [1:0]        grant_id;
    logic              tx_start;
    logic [N-1:0]      tx_din;
    logic              tx_done;

    modport slave (
        input  req, req_data, tx_done,
        output ack, err, busy, grant_id, tx_start, tx_din
    );

    modport master (
        output req, req_data, tx_done,
        input  ack, err, busy, grant_id, tx_start, tx_din
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin arbiter that lets four requesters share one UART transmitter.
// One byte is in flight at a time: IDLE -> START -> WAIT -> ACK -> IDLE.
// A transfer that sees no tx_done within TIMEOUT cycles is abandoned with an
// err pulse to its requester.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset
//   bus  uart_tx_arbiter_if.slave (req/req_data/ack/err/busy/grant_id,
//        tx_start/tx_din/tx_done)
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int N       = 8,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.slave  bus
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_ACK   = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      r_last_grant;
    logic [1:0]      r_grant_id;
    logic [N-1:0]    r_tx_din;
    logic [CW-1:0]   r_cnt;
    logic [NREQ-1:0] r_err;

    logic            w_found;
    logic [1:0]      w_winner;
    logic [1:0]      w_idx;
    logic [CW-1:0]   w_cnt_inc;
    logic [NREQ-1:0] w_grant_onehot;

    // Saturating increment: the wait counter sticks at its maximum.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + CW'(1);
    endfunction

    // Search last_grant+1 .. last_grant+4 (mod 4); the first asserted
    // request wins, so the previous winner is considered last.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_last_grant;
        w_idx    = r_last_grant;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_last_grant + 2'(k);
            if (!w_found && bus.req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_cnt_inc      = sat_inc(r_cnt);
    assign w_grant_onehot = NREQ'(1) << r_grant_id;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 2'd3;
            r_grant_id   <= 2'd0;
            r_tx_din     <= '0;
            r_cnt        <= '0;
            r_err        <= '0;
        end else begin
            r_err <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        // Byte is captured here so later req_data changes
                        // cannot disturb the transfer in progress.
                        r_tx_din     <= bus.req_data[w_winner*N +: N];
                        r_grant_id   <= w_winner;
                        r_last_grant <= w_winner;
                        r_cnt        <= '0;
                        r_state      <= S_START;
                    end
                end
                S_START: r_state <= S_WAIT;
                S_WAIT: begin
                    if (bus.tx_done) begin
                        r_state <= S_ACK;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == CNT_MAX) begin
                            // err is registered so it appears in the IDLE
                            // cycle following the last WAIT cycle.
                            r_err   <= w_grant_onehot;
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_ACK:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.tx_start = (r_state == S_START);
    assign bus.ack      = (r_state == S_ACK) ? w_grant_onehot : '0;
    assign bus.err      = r_err;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.grant_id = r_grant_id;
    assign bus.tx_din   = r_tx_din;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_tx_arbiter_if #(.N(8), .NREQ(4)) bus ();

    uart_tx_arbiter #(.N(8), .NREQ(4), .TIMEOUT(20)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [1:0] id, input logic [7:0] d);
        exp_t e;
        e.id   = id;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic do_reset;
        rst         = 1'b1;
        bus.req     = '0;
        bus.tx_done = 1'b0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    // Wait for tx_start, compare against the scoreboard head, answer with
    // tx_done d cycles after tx_start, check the ack, then load next_req.
    task automatic serve(input int d, input int lat_exp, input logic [3:0] next_req);
        int          n;
        bit          seen;
        exp_t        e;
        logic [31:0] saved;
        n    = 0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            n++;
            if (bus.tx_start === 1'b1) begin
                seen = 1;
                break;
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL serve_tx_start: tx_start not seen in 40 cycles, required within %0d", lat_exp);
            return;
        end
        n_checks++;
        if (n != lat_exp) begin
            n_fail++;
            $display("FAIL start_latency: got %0d cycles, required %0d", n, lat_exp);
        end
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_underflow: got grant %0d, required no grant", bus.grant_id);
            return;
        end
        e = sb.pop_front();
        n_checks++;
        if (bus.grant_id !== e.id) begin
            n_fail++;
            $display("FAIL grant_id: got %0d, required %0d", bus.grant_id, e.id);
        end
        n_checks++;
        if (bus.tx_din !== e.data) begin
            n_fail++;
            $display("FAIL tx_din: got %h, required %h", bus.tx_din, e.data);
        end
        // Scramble the request data while the transfer is in flight.
        saved        = bus.req_data;
        tick;
        bus.req_data = ~saved;
        n_checks++;
        if (bus.tx_start !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_one_cycle: got tx_start=%b busy=%b, required 0 1", bus.tx_start, bus.busy);
        end
        for (int j = 1; j < d; j++) tick;
        bus.tx_done = 1'b1;
        tick;
        bus.tx_done = 1'b0;
        n_checks++;
        if (bus.ack !== (4'b0001 << e.id) || bus.err !== 4'b0000) begin
            n_fail++;
            $display("FAIL ack: got ack=%b err=%b, required ack=%b err=0000", bus.ack, bus.err, 4'b0001 << e.id);
        end
        n_checks++;
        if (bus.tx_din !== e.data || bus.grant_id !== e.id) begin
            n_fail++;
            $display("FAIL hold_in_ack: got din=%h id=%0d, required din=%h id=%0d", bus.tx_din, bus.grant_id, e.data, e.id);
        end
        bus.req      = next_req;
        bus.req_data = saved;
        tick;
        n_checks++;
        if (bus.ack !== 4'b0000 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_ack: got ack=%b busy=%b, required 0000 0", bus.ack, bus.busy);
        end
    endtask

    task automatic test_reset;
        rst          = 1'b1;
        bus.req      = 4'b1111;
        bus.req_data = 32'hDEADBEEF;
        bus.tx_done  = 1'b1;
        tick;
        tick;
        n_checks++;
        if ({bus.tx_start, bus.tx_din, bus.grant_id, bus.ack, bus.err, bus.busy} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got start=%b din=%h id=%0d ack=%b err=%b busy=%b, required all 0",
                     bus.tx_start, bus.tx_din, bus.grant_id, bus.ack, bus.err, bus.busy);
        end
        bus.req     = '0;
        bus.tx_done = 1'b0;
        rst         = 1'b0;
    endtask

    task automatic test_single;
        do_reset;
        bus.req_data = {8'h44, 8'h33, 8'h22, 8'hA5};
        bus.req      = 4'b0001;
        push_exp(2'd0, 8'hA5);
        serve(10, 1, 4'b0000);
    endtask

    task automatic test_contention;
        do_reset;
        bus.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        bus.req      = 4'b1111;
        push_exp(2'd0, 8'h10);
        push_exp(2'd1, 8'h11);
        push_exp(2'd2, 8'h12);
        push_exp(2'd3, 8'h13);
        push_exp(2'd0, 8'h10);
        for (int i = 0; i < 4; i++) serve(1, 1, 4'b1111);
        serve(1, 1, 4'b0000);
    endtask

    task automatic test_fairness;
        do_reset;
        bus.req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        bus.req      = 4'b0100;
        push_exp(2'd2, 8'hC2);
        push_exp(2'd0, 8'hA0);
        push_exp(2'd2, 8'hC2);
        serve(3, 1, 4'b0101);
        serve(3, 1, 4'b0100);
        serve(3, 1, 4'b0000);
    endtask

    task automatic test_timeout;
        int   n;
        bit   seen;
        bit   ack_seen;
        exp_t e;
        do_reset;
        bus.req_data = {8'hC3, 8'h00, 8'h00, 8'h00};
        bus.req      = 4'b1000;
        push_exp(2'd3, 8'hC3);
        seen = 0;
        n    = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            n++;
            if (bus.tx_start === 1'b1) begin
                seen = 1;
                break;
            end
        end
        n_checks++;
        if (!seen || n != 1) begin
            n_fail++;
            $display("FAIL timeout_start: got seen=%0d after %0d cycles, required seen after 1", seen, n);
            return;
        end
        e = sb.pop_front();
        n_checks++;
        if (bus.grant_id !== e.id || bus.tx_din !== e.data) begin
            n_fail++;
            $display("FAIL timeout_grant: got id=%0d din=%h, required id=%0d din=%h", bus.grant_id, bus.tx_din, e.id, e.data);
        end
        n        = 0;
        seen     = 0;
        ack_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            n++;
            if (bus.ack !== 4'b0000) ack_seen = 1;
            if (bus.err !== 4'b0000) begin
                seen = 1;
                break;
            end
        end
        bus.req = 4'b0000;
        n_checks++;
        if (!seen || n < 21 || n > 22) begin
            n_fail++;
            $display("FAIL timeout_latency: got err after %0d cycles (seen=%0d), required 21..22", n, seen);
        end
        n_checks++;
        if (bus.err !== 4'b1000 || bus.busy !== 1'b0 || ack_seen) begin
            n_fail++;
            $display("FAIL timeout_err: got err=%b busy=%b ack_seen=%0d, required 1000 0 0", bus.err, bus.busy, ack_seen);
        end
        tick;
        n_checks++;
        if (bus.err !== 4'b0000 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_err_pulse: got err=%b busy=%b, required 0000 0", bus.err, bus.busy);
        end
    endtask

    task automatic test_reset_mid_wait;
        bit seen;
        do_reset;
        bus.req_data = {8'h00, 8'h00, 8'h77, 8'h5A};
        bus.req      = 4'b0001;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (bus.tx_start === 1'b1) begin
                seen = 1;
                break;
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL midwait_start: got no tx_start, required one");
            return;
        end
        tick;
        tick;
        tick;
        rst     = 1'b1;
        bus.req = 4'b0000;
        tick;
        n_checks++;
        if ({bus.tx_start, bus.tx_din, bus.grant_id, bus.ack, bus.err, bus.busy} !== 20'h0) begin
            n_fail++;
            $display("FAIL midwait_reset: got start=%b din=%h id=%0d ack=%b err=%b busy=%b, required all 0",
                     bus.tx_start, bus.tx_din, bus.grant_id, bus.ack, bus.err, bus.busy);
        end
        rst         = 1'b0;
        bus.tx_done = 1'b1;
        tick;
        bus.tx_done = 1'b0;
        n_checks++;
        if (bus.ack !== 4'b0000 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midwait_late_done: got ack=%b busy=%b, required 0000 0", bus.ack, bus.busy);
        end
        tick;
        n_checks++;
        if (bus.ack !== 4'b0000 || bus.err !== 4'b0000) begin
            n_fail++;
            $display("FAIL midwait_no_ack: got ack=%b err=%b, required 0000 0000", bus.ack, bus.err);
        end
        bus.req = 4'b0010;
        push_exp(2'd1, 8'h77);
        serve(5, 1, 4'b0000);
    endtask

    task automatic test_spurious_done;
        exp_t e;
        do_reset;
        bus.tx_done = 1'b1;
        tick;
        bus.tx_done = 1'b0;
        n_checks++;
        if ({bus.busy, bus.ack, bus.tx_start} !== 6'b0) begin
            n_fail++;
            $display("FAIL spurious_idle: got busy=%b ack=%b start=%b, required 0 0000 0", bus.busy, bus.ack, bus.tx_start);
        end
        bus.req_data = {8'h00, 8'h00, 8'h00, 8'h99};
        bus.req      = 4'b0001;
        push_exp(2'd0, 8'h99);
        tick;
        n_checks++;
        if (bus.tx_start !== 1'b1) begin
            n_fail++;
            $display("FAIL spurious_start: got tx_start=%b, required 1", bus.tx_start);
            return;
        end
        e = sb.pop_front();
        n_checks++;
        if (bus.tx_din !== e.data || bus.grant_id !== e.id) begin
            n_fail++;
            $display("FAIL spurious_grant: got din=%h id=%0d, required din=%h id=%0d", bus.tx_din, bus.grant_id, e.data, e.id);
        end
        bus.tx_done = 1'b1;
        tick;
        bus.tx_done = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b1 || bus.ack !== 4'b0000 || bus.tx_start !== 1'b0) begin
            n_fail++;
            $display("FAIL spurious_in_start: got busy=%b ack=%b start=%b, required 1 0000 0", bus.busy, bus.ack, bus.tx_start);
        end
        tick;
        tick;
        n_checks++;
        if (bus.busy !== 1'b1 || bus.ack !== 4'b0000) begin
            n_fail++;
            $display("FAIL spurious_still_wait: got busy=%b ack=%b, required 1 0000", bus.busy, bus.ack);
        end
        bus.tx_done = 1'b1;
        tick;
        bus.tx_done = 1'b0;
        bus.req     = 4'b0000;
        n_checks++;
        if (bus.ack !== 4'b0001) begin
            n_fail++;
            $display("FAIL spurious_real_ack: got ack=%b, required 0001", bus.ack);
        end
        tick;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.ack !== 4'b0000) begin
            n_fail++;
            $display("FAIL spurious_back_idle: got busy=%b ack=%b, required 0 0000", bus.busy, bus.ack);
        end
    endtask

    initial begin
        bus.req      = '0;
        bus.req_data = '0;
        bus.tx_done  = 1'b0;
        test_reset;
        test_single;
        test_contention;
        test_fairness;
        test_timeout;
        test_reset_mid_wait;
        test_spurious_done;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
